cdc_handshake_tx: RTL and testbench
===================================

Name: cdc_handshake_tx

Overview:
- Sending end of the four-phase req/ack clock-domain-crossing handshake whose receiving side is the team's synchronizer design.
- Accepts a word on a local valid/ready interface and launches it across the domain boundary.
- Holds data stable under `tx_req`, synchronizes the returning asynchronous `tx_ack` through its own flop chain, and sequences req rise/fall.
- Flags hung transfers with a timeout and counts completed transfers.

Parameters:
- DATA_W, 8, width of the transferred word.
- SYNC_STAGES, 2, flops in the `tx_ack` synchronizer chain (legal 2..4).
- TIMEOUT, 255, cycles allowed in each wait state before an error (legal 1..255, 8-bit counter).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  local word available.
- in_data  input  DATA_W  local word.
- in_ready  output  1  block can accept a word.
- tx_req  output  1  four-phase request to the receiving domain; registered.
- tx_data  output  DATA_W  launched word; registered, stable while `tx_req`=1 and until the ack falls.
- tx_ack  input  1  asynchronous acknowledge from the receiving domain.
- busy  output  1  high in any state other than IDLE.
- timeout_err  output  1  one-cycle pulse on a timeout.
- xfer_count  output  8  completed-transfer count; wraps.

Behaviour:
- Reset (`rst`=1 at an edge):
  - State goes to IDLE.
  - `tx_req`=0, `tx_data`=0, `busy`=0, `timeout_err`=0, `xfer_count`=0.
  - Synchronizer chain cleared to 0, timeout counter 0.
  - `in_ready`=1 in the cycle after reset deasserts.
  - Reset mid-transfer drops `tx_req` immediately; the in-flight word is lost and not counted.
- Ack synchronizer: `ack_s` = last stage of the SYNC_STAGES chain; FSM uses only `ack_s`, never raw `tx_ack`.
- `in_ready` = (state==IDLE), combinational from state only; it does not depend on `in_valid`.
- IDLE: on `in_valid`&`in_ready` at edge N, capture `in_data` into `tx_data`. At N+1: `tx_req`=1, state REQ, counter=0.
- REQ: wait for `ack_s`=1.
  - On `ack_s`=1: `tx_req`←0, state REL, counter=0.
  - Else counter++. When counter==TIMEOUT-1 and `ack_s`=0: pulse `timeout_err`, `tx_req`←0, state REL, counter=0.
- REL: wait for `ack_s`=0.
  - On `ack_s`=0: state IDLE. `xfer_count`++ only if REQ exited via ack, not via timeout (per-transfer flag).
  - Else counter++. At TIMEOUT-1: pulse `timeout_err`, state IDLE, no count.
- `tx_data` changes only on accept in IDLE. It holds through REQ and REL.
- Minimum transfer with an instant responder: 1 (accept) + SYNC_STAGES (ack rise) + SYNC_STAGES (ack fall) cycles; next accept is possible in the cycle IDLE is re-entered.
- `xfer_count` wraps 255→0.
- `tx_ack` high while in IDLE is ignored. The next transfer still asserts req and, since `ack_s` is already 1, completes REQ after one cycle (this is a protocol violation by the peer; no error is flagged).
- `timeout_err` is never high on two consecutive cycles from the same state.

Test Plan:
- Reset, then `in_valid`=1 `in_data`=8'hA5; responder mirrors req after 3 cycles → `tx_req` rises the cycle after accept, `tx_data`=8'hA5 stable until ack falls, `xfer_count`=1, `timeout_err` never pulses, `in_ready` returns to 1.
- Back-to-back words 8'h01..8'h04 with `in_valid` held high → four transfers in order, `tx_data` never changes while `tx_req`=1, `xfer_count`=4.
- `tx_ack` stuck at 0 with TIMEOUT=16 → `timeout_err` pulses exactly once 16 cycles after req rises, `tx_req`→0, block back in IDLE, `xfer_count` unchanged.
- `tx_ack` stuck at 1 after rising → REQ completes, REL times out after TIMEOUT cycles with one `timeout_err` pulse, `xfer_count` not incremented.
- 256 completed transfers → `xfer_count` wraps to 0.
- `rst` asserted while in REQ with `tx_req`=1 → next cycle `tx_req`=0, `busy`=0, `tx_data`=0, `xfer_count`=0; `tx_ack` glitch pulses shorter than one cycle are only ever seen by the FSM through `ack_s`.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Sending side of a four-phase req/ack clock-domain crossing: accepts a word locally,
// holds it under tx_req, and sequences req against a synchronized copy of tx_ack.
module cdc_handshake_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ack,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        xfer_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]             state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   err_q, err_d;
  logic [7:0]             count_q, count_d;
  logic                   acked_q, acked_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ack_s;

  // Only the last synchronizer stage is ever seen by the sequencing logic.
  assign ack_s = sync_q[SYNC_STAGES-1];

  // Next-state logic: accept, wait for ack rise, wait for ack fall, with per-state timeout.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], tx_ack};
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = 1'b0;
    count_d = count_q;
    acked_d = acked_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = S_REQ;
          cnt_d   = 8'd0;
          acked_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = S_REL;
          cnt_d   = 8'd0;
          acked_d = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = S_REL;
          cnt_d   = 8'd0;
          acked_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_REL: begin
        // A transfer only counts if the peer actually acknowledged it.
        if (!ack_s) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          if (acked_q) begin
            count_d = count_q + 8'd1;
          end else begin
            count_d = count_q;
          end
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      count_q <= 8'd0;
      acked_q <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
      count_q <= count_d;
      acked_q <= acked_d;
      sync_q  <= sync_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign tx_req      = req_q;
  assign tx_data     = data_q;
  assign timeout_err = err_q;
  assign xfer_count  = count_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: a behavioural responder drives tx_ack and a
// monitor logs req edges, timeout pulses and data stability for the scenario tasks to judge.
module tb_cdc_handshake_tx;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_ready, tx_req, busy, timeout_err;
  logic [7:0] tx_data, xfer_count;
  logic       tx_ack;
  logic       resp_ack = 1'b0;
  logic       glitch = 1'b0;

  assign tx_ack = resp_ack | glitch;

  cdc_handshake_tx #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack), .busy(busy),
    .timeout_err(timeout_err), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;
  int mode = 0;   // 0 mirror req after delay, 1 ack stuck low, 2 ack sticky high
  int delay = 3;

  // Monitor state.
  logic [7:0] got_q[$];
  int rise_cyc = 0, fall_cyc = 0, err_cyc = 0, acc_cyc = 0;
  int err_pulses = 0, consec = 0, stab_viol = 0, ready_viol = 0;
  logic prev_req = 1'b0, prev_err = 1'b0, prev_busy = 1'b0;
  logic [7:0] prev_data = 8'd0;

  // Responder: the receiving domain, modelled behaviourally.
  initial begin
    logic [3:0] hist;
    hist = 4'd0;
    forever begin
      @(negedge clk);
      hist = {hist[2:0], tx_req};
      case (mode)
        0: resp_ack = hist[delay-1];
        1: resp_ack = 1'b0;
        2: if (tx_req) resp_ack = 1'b1;
        default: resp_ack = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_req && !prev_req) begin rise_cyc = cyc; got_q.push_back(tx_data); end
      if (!tx_req && prev_req) fall_cyc = cyc;
      if (timeout_err) begin err_pulses++; err_cyc = cyc; if (prev_err) consec++; end
      if (busy && prev_busy && tx_data !== prev_data) stab_viol++;
      if (busy !== !in_ready) ready_viol++;
      prev_req = tx_req; prev_err = timeout_err; prev_busy = busy; prev_data = tx_data;
    end
  end

  task automatic send(input logic [7:0] d, input bit hold);
    int k;
    k = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (k >= 200) begin n_bad++; $display("FAIL send_ready: in_ready=%b required 1", in_ready); end
    acc_cyc = cyc + 1;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL wait_idle: busy=%b required 0", busy); end
  endtask

  task automatic wait_err(input int base);
    int k;
    k = 0;
    while (err_pulses == base && k < 60) begin @(negedge clk); k++; end
    n_cmp++;
    if (err_pulses != base + 1) begin
      n_bad++; $display("FAIL err_pulse: pulses=%0d required %0d", err_pulses - base, 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    @(negedge clk);
    exp_count = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: %b required 0", tx_req); end
    n_cmp++; if (tx_data !== 8'd0) begin n_bad++; $display("FAIL rst_data: %h required 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: %b required 0", busy); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: %b required 0", timeout_err); end
    n_cmp++; if (xfer_count !== 8'd0) begin n_bad++; $display("FAIL rst_count: %0d required 0", xfer_count); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: %b required 1", in_ready); end
  endtask

  task automatic test_single();
    int e0;
    mode = 0; delay = 3; e0 = err_pulses; got_q.delete();
    send(8'hA5, 1'b0);
    exp_count++;
    n_cmp++; if (rise_cyc != acc_cyc) begin n_bad++; $display("FAIL single_rise: cycle %0d required %0d", rise_cyc, acc_cyc); end
    wait_idle();
    n_cmp++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin n_bad++; $display("FAIL single_data: n=%0d required 1 word A5", got_q.size()); end
    n_cmp++; if (xfer_count !== 8'(exp_count)) begin n_bad++; $display("FAIL single_count: %0d required %0d", xfer_count, exp_count); end
    n_cmp++; if (err_pulses != e0) begin n_bad++; $display("FAIL single_noerr: pulses=%0d required 0", err_pulses - e0); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: %b required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w[4];
    w[0] = 8'h01; w[1] = 8'h02; w[2] = 8'h03; w[3] = 8'h04;
    mode = 0; delay = 1; got_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(w[i], 1'b1);
      exp_count++;
    end
    in_valid = 1'b0;
    wait_idle();
    n_cmp++; if (got_q.size() != 4) begin n_bad++; $display("FAIL b2b_n: %0d required 4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_cmp++; if (got_q[i] !== w[i]) begin n_bad++; $display("FAIL b2b_word%0d: %h required %h", i, got_q[i], w[i]); end
    end
    n_cmp++; if (xfer_count !== 8'(exp_count)) begin n_bad++; $display("FAIL b2b_count: %0d required %0d", xfer_count, exp_count); end
  endtask

  task automatic test_timeout_req();
    int e0;
    mode = 1; e0 = err_pulses;
    send(8'h3C, 1'b0);
    // Sub-cycle glitches on tx_ack must never reach the sequencing logic.
    repeat (4) begin
      #1 glitch = 1'b1; #2 glitch = 1'b0;
      @(negedge clk);
    end
    wait_err(e0);
    n_cmp++; if (err_cyc - rise_cyc != TO) begin n_bad++; $display("FAIL to_req_delay: %0d required %0d", err_cyc - rise_cyc, TO); end
    n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL to_req_req: %b required 0", tx_req); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_req_idle: busy=%b required 0", busy); end
    n_cmp++; if (xfer_count !== 8'(exp_count)) begin n_bad++; $display("FAIL to_req_count: %0d required %0d", xfer_count, exp_count); end
    repeat (3) @(negedge clk);
    n_cmp++; if (err_pulses != e0 + 1) begin n_bad++; $display("FAIL to_req_once: %0d required 1", err_pulses - e0); end
    mode = 0;
  endtask

  task automatic test_timeout_rel();
    int e0;
    mode = 2; e0 = err_pulses;
    send(8'h5A, 1'b0);
    wait_err(e0);
    n_cmp++; if (err_cyc - fall_cyc != TO) begin n_bad++; $display("FAIL to_rel_delay: %0d required %0d", err_cyc - fall_cyc, TO); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_rel_idle: busy=%b required 0", busy); end
    n_cmp++; if (xfer_count !== 8'(exp_count)) begin n_bad++; $display("FAIL to_rel_count: %0d required %0d", xfer_count, exp_count); end
    mode = 0; delay = 1;
    repeat (4) @(negedge clk);
    n_cmp++; if (err_pulses != e0 + 1) begin n_bad++; $display("FAIL to_rel_once: %0d required 1", err_pulses - e0); end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    send(8'hC3, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_req !== 1'b1) begin n_bad++; $display("FAIL mid_pre_req: %b required 1", tx_req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 0;
    n_cmp++; if (tx_req !== 1'b0) begin n_bad++; $display("FAIL mid_req: %b required 0", tx_req); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: %b required 0", busy); end
    n_cmp++; if (tx_data !== 8'd0) begin n_bad++; $display("FAIL mid_data: %h required 00", tx_data); end
    n_cmp++; if (xfer_count !== 8'd0) begin n_bad++; $display("FAIL mid_count: %0d required 0", xfer_count); end
    mode = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    do_reset();
    mode = 0;
    for (int i = 0; i < 256; i++) begin
      delay = int'($urandom_range(4, 1));
      d = 8'($urandom);
      got_q.delete();
      send(d, 1'b0);
      exp_count++;
      wait_idle();
      n_cmp++; if (got_q.size() != 1 || got_q[0] !== d) begin n_bad++; $display("FAIL wrap_data%0d: n=%0d required word %h", i, got_q.size(), d); end
      if (i == 254) begin
        n_cmp++; if (xfer_count !== 8'd255) begin n_bad++; $display("FAIL wrap_255: %0d required 255", xfer_count); end
      end
    end
    n_cmp++; if (xfer_count !== 8'(exp_count)) begin n_bad++; $display("FAIL wrap_0: %0d required %0d", xfer_count, exp_count % 256); end
  endtask

  task automatic test_invariants();
    n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL data_stable: %0d changes required 0", stab_viol); end
    n_cmp++; if (ready_viol != 0) begin n_bad++; $display("FAIL ready_busy: %0d mismatches required 0", ready_viol); end
    n_cmp++; if (consec != 0) begin n_bad++; $display("FAIL err_consec: %0d required 0", consec); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout_req();
    test_timeout_rel();
    test_reset_mid();
    test_wrap();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached required finish");
    $fatal(1, "watchdog");
  end

endmodule
